// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier: FSM states, per-step op and its decode.
package booth_pkg;

  localparam int unsigned BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } booth_state_t;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic i_q0, input logic i_q_1);
    case ({i_q0, i_q_1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/subtract M per {Q[0], q_1}, then arithmetic shift right.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);

  booth_op_t        w_op;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_op  = booth_decode(i_q[0], i_q_1);
    w_sum = i_acc;
    case (w_op)
      ADD:     w_sum = i_acc + i_m;
      SUB:     w_sum = i_acc - i_m;
      default: w_sum = i_acc;
    endcase
  end

  // {acc, Q, q_1} shifted right by one with the acc sign bit replicated
  assign o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_sequencer.sv
// Sequential radix-2 Booth multiplier controller (IDLE/LOAD/CALC/DONE, one iteration per cycle).
// Define BOOTH_START_EDGE_EN to launch only on a 0->1 edge of start instead of its level.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  booth_state_t     r_state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_q_1;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_acc_n;
  logic [WIDTH-1:0] w_q_n;
  logic             w_q_1_n;
  logic             w_launch;

`ifdef BOOTH_START_EDGE_EN
  logic r_start_q;

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) r_start_q <= 1'b0;
    else        r_start_q <= start;
  end

  assign w_launch = start & ~r_start_q;
`else
  assign w_launch = start;
`endif

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_acc (w_acc_n),
    .o_q   (w_q_n),
    .o_q_1 (w_q_1_n)
  );

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_count <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state <= LOAD;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          r_m     <= {A[WIDTH-1], A};
          r_q     <= B;
          r_acc   <= '0;
          r_q_1   <= 1'b0;
          r_count <= CW'(WIDTH);
          r_state <= CALC;
        end
        CALC: begin
          r_acc   <= w_acc_n;
          r_q     <= w_q_n;
          r_q_1   <= w_q_1_n;
          r_count <= r_count - CW'(1);
          // Product is captured from the final step's outputs on the edge entering DONE
          if (r_count <= CW'(1)) begin
            r_state <= DONE;
            done    <= 1'b1;
            product <= {w_acc_n[WIDTH-1:0], w_q_n};
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Scoreboard bench for booth_sequencer: expected products queued at launch, checked on each done pulse.
module tb_booth_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  booth_sequencer #(.WIDTH(8)) dut (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .start     (start),
    .A         (a_in),
    .B         (b_in),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: product=%h with no expected entry", product);
      end else begin
        mon_exp = exp_q.pop_front();
        if (product !== mon_exp) begin
          n_fail++;
          $display("FAIL product: got %h expected %h", product, mon_exp);
        end
      end
    end
  end

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [15:0] e;
    int k;
    e = model_mul(a, b);
    exp_q.push_back(e);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_rise: got %b expected 1", tag, busy); end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (k != 9) begin n_fail++; $display("FAIL %s latency: got %0d expected 9", tag, k); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_during_done: got %b expected 1", tag, busy); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_busy_fall: got done=%b busy=%b expected 0/0", tag, done, busy);
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (product !== e) begin n_fail++; $display("FAIL %s product_hold: got %h expected %h", tag, product, e); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h expected 0000", product); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
  endtask

  task automatic test_directed();
    run_mul(8'hF8, 8'hF8, "neg8_neg8");
    run_mul(8'h7F, 8'h80, "max_min");
    run_mul(8'h80, 8'h80, "min_min");
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 6; i++)
      run_mul(8'($urandom), 8'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    int unsigned d0;
    d0 = done_cnt;
    exp_q.push_back(16'h0000);
    a_in  = 8'h00;
    b_in  = 8'h5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    start = 1'b1;
    a_in  = 8'h7F;
    b_in  = 8'h7F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk); #1;
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL ignore_start_done_count: got %0d expected 1", done_cnt - d0);
    end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL ignore_start_product: got %h expected 0000", product); end
  endtask

  task automatic test_reset_mid();
    int unsigned d0;
    run_mul(8'h7F, 8'h7F, "pre_reset");
    a_in  = 8'h03;
    b_in  = 8'h02;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL midreset_product: got %h expected 0000", product); end
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk); #1;
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL midreset_no_done: got %0d dones expected 0", done_cnt - d0); end
    run_mul(8'h03, 8'hFB, "after_reset");
  endtask

  task automatic test_held_start();
    int stamps[$];
    int unsigned n_exp;
`ifdef BOOTH_START_EDGE_EN
    n_exp = 1;
`else
    n_exp = 3;
`endif
    for (int unsigned i = 0; i < n_exp; i++) exp_q.push_back(model_mul(8'h05, 8'hFA));
    a_in  = 8'h05;
    b_in  = 8'hFA;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 29) start = 1'b0;
      if (done === 1'b1) stamps.push_back(i);
    end
    n_checks++;
    if (stamps.size() != int'(n_exp)) begin
      n_fail++;
      $display("FAIL held_start_done_count: got %0d expected %0d", stamps.size(), n_exp);
    end else begin
      n_checks++;
      if (stamps[0] != 9) begin n_fail++; $display("FAIL held_start_first_done: got %0d expected 9", stamps[0]); end
      if (n_exp > 1) begin
        n_checks++;
        if (stamps[1] - stamps[0] != 11 || stamps[2] - stamps[1] != 11) begin
          n_fail++;
          $display("FAIL held_start_spacing: got %0d,%0d expected 11,11",
                   stamps[1] - stamps[0], stamps[2] - stamps[1]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_held_start();
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
